// File: rtl/llm_quant_pkg.sv
// llm_quant_pkg: shared FSM states and exponent sizing helpers for the block quantizer path
package llm_quant_pkg;

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    function automatic int shift_width(input int in_width);
        return $clog2(in_width + 1);
    endfunction

    function automatic int max_shift(input int in_width, input int out_width);
        return in_width - out_width + 1;
    endfunction

endpackage

// File: rtl/fixed_round_shift_sat.sv
// fixed_round_shift_sat: one element, round-half-up arithmetic right shift then saturate to OUT_WIDTH
module fixed_round_shift_sat
    import llm_quant_pkg::*;
#(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = shift_width(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0]    i_x,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic [OUT_WIDTH-1:0]   o_q
);

    localparam logic signed [IN_WIDTH:0] QMAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH:0] QMIN = ~QMAX;

    logic [IN_WIDTH:0]        w_rnd;
    logic signed [IN_WIDTH:0] w_sum;
    logic signed [IN_WIDTH:0] w_shr;

    // one extra bit keeps x + half-LSB from wrapping before the shift
    assign w_rnd = (i_shift == '0) ? '0 : {{IN_WIDTH{1'b0}}, 1'b1} << (i_shift - 1'b1);
    assign w_sum = $signed({i_x[IN_WIDTH-1], i_x}) + $signed(w_rnd);
    assign w_shr = w_sum >>> i_shift;
    assign o_q   = (w_shr > QMAX) ? QMAX[OUT_WIDTH-1:0] :
                   (w_shr < QMIN) ? QMIN[OUT_WIDTH-1:0] : w_shr[OUT_WIDTH-1:0];

endmodule

// File: rtl/block_quantizer.sv
// block_quantizer: derives a shared shift exponent from the block maximum and emits
// the block requantized to OUT_WIDTH, one row per beat.
module block_quantizer
    import llm_quant_pkg::*;
#(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int OUT_WIDTH      = 8,
    parameter int SHIFT_WIDTH    = shift_width(IN_WIDTH)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]   data_in,
    input  logic [IN_WIDTH-1:0]                          max_num,
    input  logic                                         data_in_valid,
    output logic                                         data_in_ready,
    output logic [OUT_WIDTH*IN_SIZE-1:0]                 data_out,
    output logic [SHIFT_WIDTH-1:0]                       data_out_shift,
    output logic                                         data_out_last,
    output logic                                         data_out_valid,
    input  logic                                         data_out_ready
);

    localparam int ROW_BITS = IN_WIDTH * IN_SIZE;
    localparam int RW       = (IN_PARALLELISM > 1) ? $clog2(IN_PARALLELISM) : 1;

    state_t                                       r_state;
    logic [RW-1:0]                                r_row;
    logic [IN_WIDTH*IN_SIZE*IN_PARALLELISM-1:0]   r_block;
    logic [IN_WIDTH-1:0]                          r_max;
    logic [SHIFT_WIDTH-1:0]                       r_shift;
    logic                                         r_valid;
    logic                                         r_last;
    logic [SHIFT_WIDTH-1:0]                       w_msb;
    logic [SHIFT_WIDTH-1:0]                       w_shift;
    logic [ROW_BITS-1:0]                          w_row;

    always_comb begin
        w_msb = '0;
        for (int i = 0; i < IN_WIDTH; i++) if (r_max[i]) w_msb = SHIFT_WIDTH'(i);
    end

    assign w_shift = (w_msb >= SHIFT_WIDTH'(OUT_WIDTH - 1)) ? w_msb - SHIFT_WIDTH'(OUT_WIDTH - 2) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_block <= '0;
            r_max   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (data_in_valid) begin
                    r_block <= data_in;
                    r_max   <= max_num;
                    r_state <= CALC;
                end
                CALC: begin
                    r_shift <= w_shift;
                    r_row   <= '0;
                    r_valid <= 1'b1;
                    r_last  <= (IN_PARALLELISM == 1);
                    r_state <= EMIT;
                end
                EMIT: if (data_out_ready) begin
                    if (r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= data_in_valid ? CALC : IDLE;
                        if (data_in_valid) begin
                            r_block <= data_in;
                            r_max   <= max_num;
                        end
                    end else begin
                        r_row  <= r_row + RW'(1);
                        r_last <= (r_row == RW'(IN_PARALLELISM - 2));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // new block only when idle, or when the final row leaves this cycle
    assign data_in_ready = !rst && (r_state == IDLE || (r_state == EMIT && data_out_ready && r_last));

    assign w_row          = r_block[int'(r_row)*ROW_BITS +: ROW_BITS];
    assign data_out_shift = r_shift;
    assign data_out_last  = r_last;
    assign data_out_valid = r_valid;

    for (genvar i = 0; i < IN_SIZE; i++) begin : g_q
        fixed_round_shift_sat #(
            .IN_WIDTH   (IN_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH)
        ) u_q (
            .i_x    (w_row[i*IN_WIDTH +: IN_WIDTH]),
            .i_shift(r_shift),
            .o_q    (data_out[i*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_block_quantizer.sv
// tb_block_quantizer: directed and randomized checks of block_quantizer against a behavioural model
module tb_block_quantizer;

    localparam int IW = 16, OW = 8, IS = 4, SW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [IW*IS-1:0]   d1_in = '0;
    logic [IW-1:0]      d1_max = '0;
    logic               d1_iv = 1'b0, d1_or = 1'b0;
    logic               d1_ir, d1_ov, d1_last;
    logic [OW*IS-1:0]   d1_out;
    logic [SW-1:0]      d1_shift;

    logic [IW*IS*3-1:0] d3_in = '0;
    logic [IW-1:0]      d3_max = '0;
    logic               d3_iv = 1'b0, d3_or = 1'b0;
    logic               d3_ir, d3_ov, d3_last;
    logic [OW*IS-1:0]   d3_out;
    logic [SW-1:0]      d3_shift;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [OW*IS-1:0] data;
        logic [SW-1:0]    shift;
        logic             last;
    } beat_t;

    beat_t exp_q[$];

    int mx_t[5]    = '{256, 127, 0, 511, 32768};
    int el_t[5][4] = '{'{256, -256, 255, 3}, '{127, -128, 0, -1}, '{0, 0, 0, 0},
                       '{511, -511, 510, -2}, '{-32768, 0, 0, 0}};
    int sh_t[5]    = '{2, 0, 0, 2, 9};
    int q_t[5][4]  = '{'{64, -64, 64, 1}, '{127, -128, 0, -1}, '{0, 0, 0, 0},
                       '{127, -128, 127, 0}, '{-64, 0, 0, 0}};

    always #5 clk = ~clk;

    block_quantizer #(.IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(1), .OUT_WIDTH(OW)) u1 (
        .clk(clk), .rst(rst), .data_in(d1_in), .max_num(d1_max), .data_in_valid(d1_iv),
        .data_in_ready(d1_ir), .data_out(d1_out), .data_out_shift(d1_shift),
        .data_out_last(d1_last), .data_out_valid(d1_ov), .data_out_ready(d1_or));

    block_quantizer #(.IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(3), .OUT_WIDTH(OW)) u3 (
        .clk(clk), .rst(rst), .data_in(d3_in), .max_num(d3_max), .data_in_valid(d3_iv),
        .data_in_ready(d3_ir), .data_out(d3_out), .data_out_shift(d3_shift),
        .data_out_last(d3_last), .data_out_valid(d3_ov), .data_out_ready(d3_or));

    // exponent: position of the leading one of the maximum, minus headroom for a signed OW-bit result
    function automatic int ref_shift(int mx);
        int p = 0;
        for (int b = 0; b < IW; b++) if (mx >= (1 << b)) p = b;
        return (p >= OW - 1) ? p - (OW - 2) : 0;
    endfunction

    function automatic int ref_q(int x, int sh);
        int d = 1 << sh;
        int y = x + (sh > 0 ? d / 2 : 0);
        int q = (y >= 0) ? y / d : -((-y + d - 1) / d);
        return (q > 127) ? 127 : (q < -128) ? -128 : q;
    endfunction

    function automatic logic [OW*IS-1:0] ref_row(logic [IW*IS*3-1:0] blk, int r, int mx);
        logic [OW*IS-1:0] row;
        for (int c = 0; c < IS; c++)
            row[c*OW +: OW] = 8'(ref_q(int'($signed(blk[(r*IS+c)*IW +: IW])), ref_shift(mx)));
        return row;
    endfunction

    task automatic gen_block(output logic [IW*IS*3-1:0] blk, output logic [IW-1:0] mx);
        int w, v, m;
        m = 0;
        blk = '0;
        w = $urandom_range(1, 16);
        for (int e = 0; e < IS*3; e++) begin
            v = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
            blk[e*IW +: IW] = 16'(v);
            if ((v < 0 ? -v : v) > m) m = (v < 0) ? -v : v;
        end
        mx = 16'(m);
    endtask

    task automatic push_block(logic [IW*IS*3-1:0] blk, logic [IW-1:0] mx);
        beat_t b;
        for (int r = 0; r < 3; r++) begin
            b.data  = ref_row(blk, r, int'(mx));
            b.shift = 5'(ref_shift(int'(mx)));
            b.last  = (r == 2);
            exp_q.push_back(b);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({d3_ir, d3_ov, d3_last, d3_shift, d3_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_p3: got ir=%b ov=%b last=%b sh=%0d out=%h, want all 0", d3_ir, d3_ov, d3_last, d3_shift, d3_out);
        end
        n_checks++;
        if ({d1_ir, d1_ov, d1_last, d1_shift, d1_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_p1: got ir=%b ov=%b last=%b sh=%0d out=%h, want all 0", d1_ir, d1_ov, d1_last, d1_shift, d1_out);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({d1_ir, d3_ir} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got p1=%b p3=%b, want 1 1", d1_ir, d3_ir);
        end
    endtask

    task automatic test_p1_directed;
        logic [OW*IS-1:0] exp_out;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            for (int c = 0; c < IS; c++) begin
                d1_in[c*IW +: IW]    = 16'(el_t[k][c]);
                exp_out[c*OW +: OW]  = 8'(q_t[k][c]);
            end
            d1_max = 16'(mx_t[k]);
            d1_iv  = 1'b1;
            d1_or  = 1'b1;
            #1;
            n_checks++;
            if (d1_ir !== 1'b1) begin
                n_fail++;
                $display("FAIL p1_idle_ready[%0d]: got %b, want 1", k, d1_ir);
            end
            @(negedge clk);
            d1_iv = 1'b0;
            n_checks++;
            if (d1_ov !== 1'b0) begin
                n_fail++;
                $display("FAIL p1_calc_gap[%0d]: valid got %b, want 0", k, d1_ov);
            end
            @(negedge clk);
            n_checks++;
            if ({d1_ov, d1_last, d1_shift, d1_out} !== {1'b1, 1'b1, 5'(sh_t[k]), exp_out}) begin
                n_fail++;
                $display("FAIL p1_beat[%0d]: got v=%b l=%b sh=%0d out=%h, want v=1 l=1 sh=%0d out=%h",
                         k, d1_ov, d1_last, d1_shift, d1_out, sh_t[k], exp_out);
            end
        end
        @(negedge clk);
        n_checks++;
        if (d1_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_drain: valid got %b, want 0", d1_ov);
        end
        d1_or = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [IW*IS*3-1:0] ba, bb;
        logic [IW-1:0] ma, mb;
        gen_block(ba, ma);
        gen_block(bb, mb);
        @(negedge clk);
        d3_in = ba; d3_max = ma; d3_iv = 1'b1; d3_or = 1'b1;
        @(negedge clk);
        d3_in = bb; d3_max = mb;
        n_checks++;
        if ({d3_ov, d3_ir} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_calc_a: got ov=%b ir=%b, want 0 0", d3_ov, d3_ir);
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            n_checks++;
            if ({d3_ov, d3_last, d3_ir, d3_shift, d3_out} !==
                {1'b1, r == 2, r == 2, 5'(ref_shift(int'(ma))), ref_row(ba, r, int'(ma))}) begin
                n_fail++;
                $display("FAIL b2b_a_row%0d: got v=%b l=%b ir=%b sh=%0d out=%h, want v=1 l=%0d ir=%0d sh=%0d out=%h",
                         r, d3_ov, d3_last, d3_ir, d3_shift, d3_out, r == 2, r == 2, ref_shift(int'(ma)), ref_row(ba, r, int'(ma)));
            end
        end
        @(negedge clk);
        d3_iv = 1'b0;
        n_checks++;
        if (d3_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: valid got %b, want 0", d3_ov);
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            n_checks++;
            if ({d3_ov, d3_last, d3_shift, d3_out} !==
                {1'b1, r == 2, 5'(ref_shift(int'(mb))), ref_row(bb, r, int'(mb))}) begin
                n_fail++;
                $display("FAIL b2b_b_row%0d: got v=%b l=%b sh=%0d out=%h, want v=1 l=%0d sh=%0d out=%h",
                         r, d3_ov, d3_last, d3_shift, d3_out, r == 2, ref_shift(int'(mb)), ref_row(bb, r, int'(mb)));
            end
        end
        @(negedge clk);
        n_checks++;
        if ({d3_ov, d3_ir} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_idle: got ov=%b ir=%b, want 0 1", d3_ov, d3_ir);
        end
    endtask

    task automatic test_backpressure;
        logic [IW*IS*3-1:0] blk;
        logic [IW-1:0] mx;
        beat_t cur, saved, ex;
        int sent = 0, cyc = 0;
        bit hold = 0, acc = 0;
        saved = '0;
        while (cyc < 2000 && (sent < 20 || exp_q.size() > 0)) begin
            @(negedge clk);
            cyc++;
            if (acc) d3_iv = 1'b0;
            acc = 0;
            cur.data = d3_out; cur.shift = d3_shift; cur.last = d3_last;
            if (hold) begin
                n_checks++;
                if (d3_ov !== 1'b1 || cur !== saved) begin
                    n_fail++;
                    $display("FAIL bp_stable: got v=%b beat=%h, want v=1 beat=%h", d3_ov, cur, saved);
                end
            end
            d3_or = 1'($urandom_range(0, 1));
            if (sent < 20 && !d3_iv && $urandom_range(0, 3) != 0) begin
                gen_block(blk, mx);
                d3_in = blk; d3_max = mx; d3_iv = 1'b1;
            end
            #1;
            if (d3_ov && d3_or) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_row: got beat=%h, want no row", cur);
                end else begin
                    ex = exp_q.pop_front();
                    if (cur !== ex) begin
                        n_fail++;
                        $display("FAIL bp_row: got beat=%h, want %h", cur, ex);
                    end
                end
            end
            if (d3_iv && d3_ir) begin
                push_block(d3_in, d3_max);
                sent++;
                acc = 1;
            end
            hold = d3_ov && !d3_or;
            saved = cur;
        end
        @(negedge clk);
        d3_iv = 1'b0;
        d3_or = 1'b0;
        n_checks++;
        if (sent != 20 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_complete: got sent=%0d pending=%0d, want 20 0", sent, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_emit;
        logic [IW*IS*3-1:0] blk;
        logic [IW-1:0] mx;
        gen_block(blk, mx);
        @(negedge clk);
        d3_in = blk; d3_max = mx; d3_iv = 1'b1; d3_or = 1'b1;
        @(negedge clk);
        d3_iv = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({d3_ov, d3_last, d3_out} !== {1'b1, 1'b0, ref_row(blk, 1, int'(mx))}) begin
            n_fail++;
            $display("FAIL rst_pre_row1: got v=%b l=%b out=%h, want v=1 l=0 out=%h", d3_ov, d3_last, d3_out, ref_row(blk, 1, int'(mx)));
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({d3_ir, d3_ov, d3_last, d3_shift, d3_out} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got ir=%b ov=%b last=%b sh=%0d out=%h, want all 0", d3_ir, d3_ov, d3_last, d3_shift, d3_out);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (d3_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %b, want 1", d3_ir);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (d3_ov !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale_row[%0d]: valid got %b, want 0", i, d3_ov);
            end
        end
        gen_block(blk, mx);
        d3_in = blk; d3_max = mx; d3_iv = 1'b1;
        @(negedge clk);
        d3_iv = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({d3_ov, d3_shift, d3_out} !== {1'b1, 5'(ref_shift(int'(mx))), ref_row(blk, 0, int'(mx))}) begin
            n_fail++;
            $display("FAIL rst_new_row0: got v=%b sh=%0d out=%h, want v=1 sh=%0d out=%h",
                     d3_ov, d3_shift, d3_out, ref_shift(int'(mx)), ref_row(blk, 0, int'(mx)));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_p1_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
